// File: rtl/bbc_timing_pkg.sv
// Shared timing constants and stretch FSM state type for the 1 MHz bus logic.
`timescale 1ns/1ps
package bbc_timing_pkg;

    localparam int unsigned HALF_DIV_DEF = 16;
    localparam int unsigned PERIOD_1M    = 2 * HALF_DIV_DEF;
    localparam int unsigned CNT_W        = $clog2(PERIOD_1M);
    localparam int unsigned REM_W        = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        STRETCH = 1'b1
    } stretch_state_e;

endpackage

// File: rtl/clken_divider.sv
// Free-running 1 MHz phase counter: registered phi2 plus look-ahead boundary strobes.
`timescale 1ns/1ps
module clken_divider
    import bbc_timing_pkg::*;
#(
    parameter int unsigned HALF_DIV = HALF_DIV_DEF
) (
    input  logic clock,
    input  logic reset_n,
    output logic mid_c,
    output logic end_c,
    output logic mhz1_phi2
);

    localparam int unsigned PERIOD = 2 * HALF_DIV;
    localparam int unsigned W      = $clog2(PERIOD);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         phi2_q;
    logic         phi2_d;

    // Next count wraps naturally because PERIOD is a power of two; strobes flag the value
    // cnt is about to take, so the consumer's registered outputs line up with cnt.
    always_comb begin
        cnt_d  = cnt_q + W'(1);
        mid_c  = (cnt_d == W'(HALF_DIV - 1));
        end_c  = (cnt_d == W'(PERIOD - 1));
        phi2_d = cnt_d[W-1];
    end

    // Counter and phi2 registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            phi2_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            phi2_q <= phi2_d;
        end
    end

    assign mhz1_phi2 = phi2_q;

endmodule

// File: rtl/mhz1_bus_stretch.sv
// CPU clock-enable generator that stretches 1 MHz peripheral accesses onto the 1 MHz phase.
`timescale 1ns/1ps
module mhz1_bus_stretch
    import bbc_timing_pkg::*;
#(
    parameter int unsigned HALF_DIV = HALF_DIV_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic mhz1_enable,
    input  logic hold,
    output logic cpu_clken,
    output logic mhz1_clken,
    output logic mhz1_phi2,
    output logic io_cycle
);

    logic             mid_c;
    logic             end_c;
    stretch_state_e   state_q;
    stretch_state_e   state_d;
    logic [REM_W-1:0] rem_q;
    logic [REM_W-1:0] rem_d;
    logic             cpu_clken_q;
    logic             cpu_clken_d;
    logic             mhz1_clken_q;
    logic             mhz1_clken_d;
    logic             io_cycle_q;
    logic             io_cycle_d;

    clken_divider #(
        .HALF_DIV (HALF_DIV)
    ) u_div (
        .clock     (clock),
        .reset_n   (reset_n),
        .mid_c     (mid_c),
        .end_c     (end_c),
        .mhz1_phi2 (mhz1_phi2)
    );

    // Boundary decisions; a misaligned entry owes one suppression, paid at the next mid
    // boundary, so every 1 MHz access exits on an end boundary.
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        cpu_clken_d  = 1'b0;
        mhz1_clken_d = end_c;
        case (state_q)
            IDLE: begin
                if ((mid_c || end_c) && !hold) begin
                    if (mhz1_enable) begin
                        state_d = STRETCH;
                        rem_d   = end_c ? REM_W'(1) : REM_W'(0);
                    end else begin
                        cpu_clken_d = 1'b1;
                    end
                end
            end
            STRETCH: begin
                if (mid_c && (rem_q != '0)) begin
                    rem_d = rem_q - REM_W'(1);
                end else if (end_c) begin
                    if (rem_q != '0) begin
                        rem_d = rem_q - REM_W'(1);
                    end else if (!hold) begin
                        cpu_clken_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                rem_d   = '0;
            end
        endcase
        io_cycle_d = (state_q == STRETCH) || (state_d == STRETCH);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            cpu_clken_q  <= 1'b0;
            mhz1_clken_q <= 1'b0;
            io_cycle_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            cpu_clken_q  <= cpu_clken_d;
            mhz1_clken_q <= mhz1_clken_d;
            io_cycle_q   <= io_cycle_d;
        end
    end

    assign cpu_clken  = cpu_clken_q;
    assign mhz1_clken = mhz1_clken_q;
    assign io_cycle   = io_cycle_q;

endmodule

// File: tb/tb_mhz1_bus_stretch.sv
// Bench for mhz1_bus_stretch: vector table, corner-case sequences and random stimulus vs a phase model.
`timescale 1ns/1ps
module tb_mhz1_bus_stretch;

    localparam int HD = 16;
    localparam int P  = 2 * HD;

    logic clock = 1'b0;
    logic reset_n;
    logic mhz1_enable;
    logic hold;
    logic cpu_clken;
    logic mhz1_clken;
    logic mhz1_phi2;
    logic io_cycle;

    mhz1_bus_stretch #(.HALF_DIV(HD)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .mhz1_enable (mhz1_enable),
        .hold        (hold),
        .cpu_clken   (cpu_clken),
        .mhz1_clken  (mhz1_clken),
        .mhz1_phi2   (mhz1_phi2),
        .io_cycle    (io_cycle)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit en;
        bit hold;
        int ncyc;
        bit clk;
        bit io;
        bit phi2;
        bit mclk;
    } vec_t;

    vec_t tbl[17];

    int total = 0;
    int bad   = 0;

    // Model: phase position within the 1 MHz period and whether a 1 MHz access is open.
    int mcnt;
    bit in_acc;
    bit e_clk, e_mclk, e_phi2, e_io;
    int cyc;
    int last_clk;
    int last_gap;

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (model cnt=%0d)", name, act, exp, mcnt);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mcnt     = 0;
        in_acc   = 1'b0;
        e_clk    = 1'b0;
        e_mclk   = 1'b0;
        e_phi2   = 1'b0;
        e_io     = 1'b0;
        cyc      = 0;
        last_clk = 0;
        last_gap = -1;
    endtask

    // A CPU cycle ends every half period; a 1 MHz access opens at a free boundary and
    // closes at the first later end-of-period with hold low.
    task automatic model_step(input bit en, input bit h);
        bit was;
        bit bnd;
        bit is_e;
        mcnt  = (mcnt + 1) % P;
        bnd   = (mcnt % HD) == HD - 1;
        is_e  = (mcnt == P - 1);
        was   = in_acc;
        e_clk = 1'b0;
        if (!in_acc) begin
            if (bnd && !h) begin
                if (en) in_acc = 1'b1;
                else    e_clk  = 1'b1;
            end
        end else if (is_e && !h) begin
            in_acc = 1'b0;
            e_clk  = 1'b1;
        end
        e_io   = was || in_acc;
        e_phi2 = (mcnt >= HD);
        e_mclk = is_e;
    endtask

    // Called at a falling edge: apply inputs, advance one clock, compare against the model.
    task automatic step(input bit en, input bit h);
        mhz1_enable = en;
        hold        = h;
        @(posedge clock);
        model_step(en, h);
        @(negedge clock);
        cyc++;
        check("cpu_clken", cpu_clken, e_clk);
        check("mhz1_clken", mhz1_clken, e_mclk);
        check("mhz1_phi2", mhz1_phi2, e_phi2);
        check("io_cycle", io_cycle, e_io);
        if (cpu_clken === 1'b1) begin
            last_gap = cyc - last_clk;
            last_clk = cyc;
        end
    endtask

    task automatic run_to(input int target, input bit en, input bit h);
        for (int i = 0; i < P; i++) begin
            step(en, h);
            if (mcnt == target) return;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_clken"}, cpu_clken, 1'b0);
        check({tag, "_mhz1_clken"}, mhz1_clken, 1'b0);
        check({tag, "_phi2"}, mhz1_phi2, 1'b0);
        check({tag, "_io_cycle"}, io_cycle, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // {en, hold, cycles, cpu_clken, io_cycle, phi2, mhz1_clken} at the last cycle
        tbl[0]  = '{1'b0, 1'b0, 14, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0,  1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 15, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 14, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0,  1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 16, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 15, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 15, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b0,  1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 16, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 16, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 15, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b1, 1'b1};

        reset_n     = 1'b0;
        mhz1_enable = 1'b0;
        hold        = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Vector table from reset release
        for (int v = 0; v < 17; v++) begin
            for (int k = 0; k < tbl[v].ncyc; k++) step(tbl[v].en, tbl[v].hold);
            check($sformatf("vec%0d_cpu_clken", v), cpu_clken, tbl[v].clk);
            check($sformatf("vec%0d_io_cycle", v), io_cycle, tbl[v].io);
            check($sformatf("vec%0d_phi2", v), mhz1_phi2, tbl[v].phi2);
            check($sformatf("vec%0d_mhz1_clken", v), mhz1_clken, tbl[v].mclk);
        end

        // Aligned access with hold at the exit end boundary: stretches by a full period
        run_to(14, 1'b0, 1'b0);
        step(1'b1, 1'b0);
        run_to(30, 1'b0, 1'b0);
        step(1'b0, 1'b1);
        run_to(15, 1'b0, 1'b1);
        run_to(31, 1'b0, 1'b0);
        check_int("gap_hold_at_exit", last_gap, 64);

        // Misaligned access entered at the end boundary
        run_to(15, 1'b0, 1'b0);
        run_to(30, 1'b0, 1'b0);
        step(1'b1, 1'b0);
        run_to(31, 1'b1, 1'b0);
        check_int("gap_misaligned", last_gap, 48);

        // Back-to-back aligned accesses with enable toggling during the stretch
        for (int it = 0; it < 3; it++) begin
            run_to(15, 1'b1, 1'b0);
            for (int k = 0; k < HD; k++) step(1'($urandom % 2), 1'b0);
            check_int($sformatf("gap_back_to_back%0d", it), last_gap, 32);
        end

        // Asynchronous reset in the middle of a stretch
        run_to(14, 1'b0, 1'b0);
        step(1'b1, 1'b0);
        run_to(20, 1'b1, 1'b0);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        mhz1_enable = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check_reset_outputs("held_reset");
        reset_n = 1'b1;
        model_reset();
        run_to(14, 1'b0, 1'b0);
        check("post_reset_io_cycle", io_cycle, 1'b0);
        step(1'b0, 1'b0);
        check_int("first_clken_after_reset", last_gap, 15);

        // Random enable/hold against the model
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom % 2), 1'(($urandom % 4) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
